// File: rtl/hazard_pkg.sv
// hazard_pkg: shared Tuse/Tnew encodings, MDU latency defaults and scoreboard helpers
package hazard_pkg;
  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_M    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;
  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;
  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [1:0] tnew;
  } sb_entry_t;
  // a producer blocks a consumer only if its result arrives after the consumer needs it
  function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] ra, input logic [1:0] tu);
    return e.we && e.addr != 5'd0 && e.addr == ra && tu != TUSE_NONE && tu < e.tnew;
  endfunction
  // one stage older: result is one cycle closer, never below zero
  function automatic sb_entry_t sb_age(input sb_entry_t e);
    sb_entry_t r;
    r = e;
    r.tnew = (e.tnew != 2'd0) ? e.tnew - 2'd1 : 2'd0;
    return r;
  endfunction
endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter: counts down the HI/LO busy window of a multiply or divide
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_div,
  output logic o_busy
);
  logic [3:0] r_cnt;
  // load the operation latency on an accepted start, otherwise drain to idle
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else r_cnt <= i_load ? (i_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES)) : r_cnt - 4'(r_cnt != 4'd0);
  assign o_busy = r_cnt != 4'd0;
endmodule

// File: rtl/stall_controller.sv
// stall_controller: Tnew/Tuse hazard stall unit; STALL_MDU_EN adds the HI/LO busy counter
// The W entry is never compared (its Tnew is always 0), so only E and M are stored.
module stall_controller
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RA1_D,
  input  logic [4:0] RA2_D,
  input  logic [1:0] Tuse_rs_D,
  input  logic [1:0] Tuse_rt_D,
  input  logic       WriteReg_D,
  input  logic [4:0] Waddr_D,
  input  logic [1:0] Tnew_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  input  logic       flush,
  output logic       Stall,
  output logic       Clr_E,
  output logic       md_busy
);
  sb_entry_t r_e, r_m, w_d;
  logic w_stall_reg, w_stall_md, w_md_busy;
  assign w_d = '{we: WriteReg_D, addr: Waddr_D, tnew: Tnew_D};
  assign w_stall_reg = sb_hit(r_e, RA1_D, Tuse_rs_D) | sb_hit(r_e, RA2_D, Tuse_rt_D)
                     | sb_hit(r_m, RA1_D, Tuse_rs_D) | sb_hit(r_m, RA2_D, Tuse_rt_D);
  assign Stall   = w_stall_reg | w_stall_md;
  assign Clr_E   = Stall;
  assign md_busy = w_md_busy;
  // advance the producer scoreboard; a stall or flush puts a bubble into E
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_e <= '0;
      r_m <= '0;
    end else begin
      r_e <= (!Stall && !flush) ? w_d : '0;
      r_m <= sb_age(r_e);
    end
`ifdef STALL_MDU_EN
  md_busy_counter #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md_busy_counter (
    .clk   (clk),
    .reset (reset),
    .i_load(md_start_D && !Stall && !flush),
    .i_div (md_div_D),
    .o_busy(w_md_busy)
  );
  assign w_stall_md = md_use_D && w_md_busy;
`else
  logic w_unused_md;
  assign w_unused_md = ^{md_start_D, md_div_D, md_use_D, 4'(MULT_CYCLES), 4'(DIV_CYCLES)};
  assign w_md_busy   = 1'b0;
  assign w_stall_md  = 1'b0;
`endif
endmodule

// File: tb/tb_stall_controller.sv
// tb_stall_controller: scoreboard bench for the stall unit (MDU part follows STALL_MDU_EN)
module tb_stall_controller;
  logic clk, reset;
  logic [4:0] RA1_D, RA2_D, Waddr_D;
  logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_D;
  logic WriteReg_D, md_start_D, md_div_D, md_use_D, flush;
  logic Stall, Clr_E, md_busy;
  int checks = 0, errors = 0;
  logic [1:0] exp_q[$];

  stall_controller dut (
    .clk(clk), .reset(reset), .RA1_D(RA1_D), .RA2_D(RA2_D), .Tuse_rs_D(Tuse_rs_D),
    .Tuse_rt_D(Tuse_rt_D), .WriteReg_D(WriteReg_D), .Waddr_D(Waddr_D), .Tnew_D(Tnew_D),
    .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D), .flush(flush),
    .Stall(Stall), .Clr_E(Clr_E), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // drive one D-stage cycle, queue its expected outputs, compare at the negedge
  task automatic cyc(input string tag, input logic [4:0] ra1, input logic [1:0] tu1,
                     input logic [4:0] ra2, input logic [1:0] tu2, input logic we,
                     input logic [4:0] wa, input logic [1:0] tn, input logic ms,
                     input logic md, input logic mu, input logic fl,
                     input logic es, input logic eb);
    logic [1:0] e;
    RA1_D = ra1; Tuse_rs_D = tu1; RA2_D = ra2; Tuse_rt_D = tu2;
    WriteReg_D = we; Waddr_D = wa; Tnew_D = tn;
    md_start_D = ms; md_div_D = md; md_use_D = mu; flush = fl;
    exp_q.push_back({es, eb});
    @(negedge clk);
    if (exp_q.size() == 0) chk({tag, "_q"}, 4'd0, 4'd1);
    else begin
      e = exp_q.pop_front();
      chk({tag, "_stall"}, {3'd0, Stall}, {3'd0, e[1]});
      chk({tag, "_clr"}, {3'd0, Clr_E}, {3'd0, e[1]});
      chk({tag, "_busy"}, {3'd0, md_busy}, {3'd0, e[0]});
    end
    @(posedge clk); #1;
  endtask

  task automatic prod(input string tag, input logic [4:0] wa, input logic [1:0] tn, input logic es);
    cyc(tag, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, wa, tn, 1'b0, 1'b0, 1'b0, 1'b0, es, 1'b0);
  endtask

  task automatic cons(input string tag, input logic [4:0] ra, input logic [1:0] tu, input logic es);
    cyc(tag, ra, tu, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, es, 1'b0);
  endtask

  initial begin
    {RA1_D, RA2_D, Waddr_D, Tnew_D, WriteReg_D, md_start_D, md_div_D, md_use_D, flush} = '0;
    Tuse_rs_D = 2'd3; Tuse_rt_D = 2'd3;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {3'd0, Stall}, 4'd0);
    chk("rst_busy", {3'd0, md_busy}, 4'd0);
    reset = 1'b0;
    // load then ALU consumer: one stall
    prod("t1_lw", 5'd2, 2'd2, 1'b0);
    cons("t1_use", 5'd2, 2'd1, 1'b1);
    cons("t1_go", 5'd2, 2'd1, 1'b0);
    // load then branch: two stalls; ALU then branch: one
    prod("t2_lw", 5'd5, 2'd2, 1'b0);
    cons("t2_beq0", 5'd5, 2'd0, 1'b1);
    cons("t2_beq1", 5'd5, 2'd0, 1'b1);
    cons("t2_beq2", 5'd5, 2'd0, 1'b0);
    prod("t2_add", 5'd5, 2'd1, 1'b0);
    cons("t2_abeq0", 5'd5, 2'd0, 1'b1);
    cons("t2_abeq1", 5'd5, 2'd0, 1'b0);
    // rt path, and rs+rt on the same producer
    prod("rt_lw", 5'd6, 2'd2, 1'b0);
    cyc("rt_use", 5'd1, 2'd1, 5'd6, 2'd1, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("rt_go", 5'd1, 2'd1, 5'd6, 2'd1, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    prod("both_lw", 5'd8, 2'd2, 1'b0);
    cyc("both_use", 5'd8, 2'd1, 5'd8, 2'd1, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("both_go", 5'd8, 2'd1, 5'd8, 2'd1, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // $0 and unused operands never stall
    prod("z_lw", 5'd0, 2'd2, 1'b0);
    cons("z_use0", 5'd0, 2'd0, 1'b0);
    cons("z_use1", 5'd0, 2'd0, 1'b0);
    prod("n_lw", 5'd9, 2'd2, 1'b0);
    cons("n_use", 5'd9, 2'd3, 1'b0);
    // flushed producer becomes a bubble
    cyc("f_lw", 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cons("f_use0", 5'd7, 2'd0, 1'b0);
    cons("f_use1", 5'd7, 2'd0, 1'b0);
    // flush during a stall: Stall still reflects D, M hit keeps it one more cycle
    prod("fs_lw", 5'd4, 2'd2, 1'b0);
    cyc("fs_both", 5'd4, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cons("fs_m", 5'd4, 2'd0, 1'b1);
    cons("fs_go", 5'd4, 2'd0, 1'b0);
`ifdef STALL_MDU_EN
    cyc("div", 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc("mflo_wait", 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc("mflo_go", 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("mult", 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc("mult_flush", 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc("mult_done", 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    cyc("div", 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("mflo0", 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("mflo1", 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    // asynchronous reset in the middle of a load stall
    prod("r_lw", 5'd3, 2'd2, 1'b0);
    RA1_D = 5'd3; Tuse_rs_D = 2'd1;
    @(negedge clk);
    chk("r_pre", {3'd0, Stall}, 4'd1);
    reset = 1'b1;
    #1;
    chk("r_async", {3'd0, Stall}, 4'd0);
    chk("r_async_clr", {3'd0, Clr_E}, 4'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cons("r_post0", 5'd3, 2'd1, 1'b0);
    cons("r_post1", 5'd3, 2'd0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
